// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Multiply is shift-add and divide is restoring division, one bit per cycle.
// Signed operands are converted to magnitudes on issue. Signs are applied in FIX.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned ACC_W = 2 * WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [ACC_W-1:0] acc_q, acc_d;      // mul: {partial, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0] opnd_q, opnd_d;    // multiplicand or divisor magnitude
    logic             is_div_q, is_div_d;
    logic             neg_lo_q, neg_lo_d; // negate product / quotient
    logic             neg_hi_q, neg_hi_d; // negate remainder
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    logic             sgn_a, sgn_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_trial;
    logic [ACC_W-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    // Operand magnitudes and per-step datapath arithmetic
    always_comb begin
        sgn_a     = ~op[0] & a[WIDTH-1];
        sgn_b     = ~op[0] & b[WIDTH-1];
        mag_a     = sgn_a ? WIDTH'(-a) : a;
        mag_b     = sgn_b ? WIDTH'(-b) : b;
        mul_sum   = {1'b0, acc_q[ACC_W-1:WIDTH]} + {1'b0, opnd_q};
        div_shift = {acc_q[ACC_W-1:WIDTH], acc_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, opnd_q};
        prod_fix  = neg_lo_q ? ACC_W'(-acc_q) : acc_q;
        quo_fix   = neg_lo_q ? WIDTH'(-acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
        rem_fix   = neg_hi_q ? WIDTH'(-acc_q[ACC_W-1:WIDTH]) : acc_q[ACC_W-1:WIDTH];
    end

    // Next-state, datapath step and HI/LO update
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        if (state_q == S_IDLE) begin
            if (start && !cancel) begin
                count_d  = '0;
                is_div_d = op[1];
                neg_hi_d = op[1] & sgn_a;
                if (op[1]) begin
                    // Divide by zero keeps an all-ones quotient regardless of signs
                    neg_lo_d = (sgn_a ^ sgn_b) & (b != '0);
                    acc_d    = {{WIDTH{1'b0}}, mag_a};
                    opnd_d   = mag_b;
                    state_d  = S_DIV;
                end else begin
                    neg_lo_d = sgn_a ^ sgn_b;
                    acc_d    = {{WIDTH{1'b0}}, mag_b};
                    opnd_d   = mag_a;
                    state_d  = S_MUL;
                end
            end else if (!start) begin
                if (mthi) hi_d = wdata;
                if (mtlo) lo_d = wdata;
            end
        end else if (cancel) begin
            state_d = S_IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                S_MUL: begin
                    acc_d = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[ACC_W-1:1]};
                    if (count_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
                    else count_d = count_q + CNT_W'(1);
                end
                S_DIV: begin
                    if (!div_trial[WIDTH]) acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    else acc_d = {acc_q[ACC_W-2:0], 1'b0};
                    if (count_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
                    else count_d = count_q + CNT_W'(1);
                end
                S_FIX: begin
                    if (is_div_q) begin
                        lo_d = quo_fix;
                        hi_d = rem_fix;
                    end else begin
                        lo_d = prod_fix[WIDTH-1:0];
                        hi_d = prod_fix[ACC_W-1:WIDTH];
                    end
                    done_d  = 1'b1;
                    count_d = '0;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign done = done_q;
    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random ops
// checked against an arithmetic reference model.
module tb_mult_div_unit;

    localparam int unsigned W = 32;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         cancel, mthi, mtlo;
    logic [W-1:0] wdata;
    logic [W-1:0] hi, lo;
    logic         busy, done;

    int n_cmp = 0;
    int n_err = 0;

    mult_div_unit #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference result {hi, lo} from plain integer arithmetic
    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, q, r;
        logic [63:0] qv, rv;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'd0: begin
                q = sx * sy;
                return 64'(q);
            end
            2'd1: return {32'b0, x} * {32'b0, y};
            2'd2: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                q  = sx / sy;
                r  = sx % sy;
                qv = 64'(q);
                rv = 64'(r);
                return {rv[31:0], qv[31:0]};
            end
            default: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    // Issue one op (optionally right at the current negedge) and check latency and result.
    // poke_at > 0 re-asserts start/mthi with junk on that busy cycle to show it is ignored.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [63:0] exp, input bit imm,
                          input int poke_at);
        int cycles;
        if (!imm) @(negedge clock);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clock);
        start = 1'b0;
        cycles = 0;
        while (busy && cycles < 100) begin
            cycles++;
            if (cycles == poke_at) begin
                start = 1'b1; op = ~o; a = $urandom; b = $urandom;
                mthi = 1'b1; wdata = $urandom;
            end else begin
                start = 1'b0; mthi = 1'b0;
            end
            @(negedge clock);
        end
        start = 1'b0; mthi = 1'b0;
        check_eq({tag, "_busy_cycles"}, 64'(cycles), 64'd33);
        check_eq({tag, "_done"}, {63'b0, done}, 64'd1);
        check_eq({tag, "_hilo"}, {hi, lo}, exp);
    endtask

    logic [31:0] pool [6];

    function automatic logic [31:0] pick();
        int k;
        k = int'($urandom_range(0, 9));
        if (k < 6) return pool[k];
        return $urandom;
    endfunction

    initial begin
        int dones;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        pool[0] = 32'h0;        pool[1] = 32'h1;        pool[2] = 32'hFFFF_FFFF;
        pool[3] = 32'h8000_0000; pool[4] = 32'h7FFF_FFFF; pool[5] = 32'h0000_0007;

        reset = 1'b1; start = 1'b0; op = 2'd0; a = '0; b = '0;
        cancel = 1'b0; mthi = 1'b0; mtlo = 1'b0; wdata = '0;
        repeat (2) @(negedge clock);
        check_eq("reset_hilo", {hi, lo}, 64'd0);
        check_eq("reset_busy_done", {62'b0, busy, done}, 64'd0);
        reset = 1'b0;

        run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, 1'b0, 0);
        @(negedge clock);
        check_eq("done_one_cycle", {63'b0, done}, 64'd0);
        run_op("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'd7, {32'hFFFF_FFFF, 32'hFFFF_FFEB}, 1'b0, 0);
        run_op("mult_min", 2'd0, 32'h8000_0000, 32'h8000_0000, {32'h4000_0000, 32'h0}, 1'b0, 0);
        run_op("div_neg", 2'd2, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0, 0);
        run_op("divu", 2'd3, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, 0);
        run_op("div_zero", 2'd2, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 1'b0, 0);
        run_op("div_zero_neg", 2'd2, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, 1'b0, 0);
        run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 1'b0, 0);

        // HI/LO moves
        @(negedge clock); mthi = 1'b1; wdata = 32'h1234;
        @(negedge clock); mthi = 1'b0; mtlo = 1'b1; wdata = 32'h5678;
        @(negedge clock); mtlo = 1'b0;
        check_eq("mthi_mtlo", {hi, lo}, {32'h1234, 32'h5678});

        // Cancel mid-divide
        start = 1'b1; op = 2'd3; a = 32'd100; b = 32'd7;
        @(negedge clock); start = 1'b0;
        repeat (4) @(negedge clock);
        cancel = 1'b1;
        @(negedge clock); cancel = 1'b0;
        check_eq("cancel_busy", {63'b0, busy}, 64'd0);
        check_eq("cancel_hilo", {hi, lo}, {32'h1234, 32'h5678});
        dones = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) dones++;
        end
        check_eq("cancel_no_done", 64'(dones), 64'd0);

        // Start and mthi while busy are ignored
        run_op("start_in_busy", 2'd3, 32'd1000, 32'd33, {32'd10, 32'd30}, 1'b0, 10);

        // Back-to-back issue on the done cycle
        run_op("b2b_mul", 2'd1, 32'd3, 32'd4, {32'd0, 32'd12}, 1'b0, 0);
        run_op("b2b_div", 2'd3, 32'd12, 32'd5, {32'd2, 32'd2}, 1'b1, 0);

        // Random ops against the reference model
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = pick();
            rb = pick();
            run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, ref_result(ro, ra, rb), 1'b0, 0);
        end

        // Reset in the middle of a multiply
        @(negedge clock);
        start = 1'b1; op = 2'd1; a = 32'd9; b = 32'd9;
        @(negedge clock); start = 1'b0;
        repeat (10) @(negedge clock);
        reset = 1'b1;
        #1;
        check_eq("midreset_busy_done", {62'b0, busy, done}, 64'd0);
        check_eq("midreset_hilo", {hi, lo}, 64'd0);
        @(negedge clock); reset = 1'b0;
        dones = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) dones++;
        end
        check_eq("midreset_no_done", 64'(dones), 64'd0);
        run_op("after_reset", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'h0, 32'h1}, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
